alarm_scheduler: RTL and testbench
==================================

Name: alarm_scheduler

Overview:
Multi-slot alarm controller on the 1 Hz time base. It holds N programmable alarm times and compares each against the running time-of-day count. It arbitrates simultaneous or overlapping matches through a pending queue with fixed priority, and sequences the LED ring / snooze / dismiss cycle. It replaces the single hard-wired comparator that drives led3, and needs no compare-offset fudge.

Parameters:
N_SLOTS, 4, number of alarm slots (1..8)
TIME_W, 21, width of the time-of-day count
RING_SECS, 60, clk_1hz cycles one ring burst lasts
SNOOZE_SECS, 300, clk_1hz cycles of snooze delay
MAX_SNOOZE, 3, snoozes allowed per alarm event
IDX_W, 2, slot index width, >= clog2(N_SLOTS)

Ports:
clk_1hz  in  1  1 Hz system clock, rising edge
rst_n  in  1  asynchronous active-low reset
count  in  TIME_W  current time-of-day count
wr_en  in  1  write one slot this cycle
wr_idx  in  IDX_W  slot to write
wr_time  in  TIME_W  alarm time for the slot
wr_on  in  1  slot enable value
snooze  in  1  snooze request, level sampled per edge
dismiss  in  1  dismiss request, level sampled per edge
led3  out  1  alarm LED, toggles while ringing
ringing  out  1  high in RING state
active_idx  out  IDX_W  slot being serviced, valid when not IDLE
pending  out  N_SLOTS  matched-but-unserviced slots
snooze_left  out  2  snoozes remaining for the current event

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; led3=0; ringing=0; active_idx=0; pending=0; snooze_left=MAX_SNOOZE.
  - All slot times=0 and all slots disabled; prev_count=0.
  - Reset mid-ring or mid-snooze aborts the event immediately, with no residual pending.
- Slot registers:
  - On wr_en with wr_idx<N_SLOTS: slot time=wr_time, slot enable=wr_on, and that slot's pending bit clears.
  - wr_idx>=N_SLOTS is ignored.
  - Writing the active slot does not abort an event in progress.
- Match detect:
  - prev_count registers count every edge.
  - Slot k matches when enable[k] is set, count==time[k] and count!=prev_count. A paused or held clock therefore fires once.
  - A match sets pending[k] at the same edge.
  - A match on a slot already pending is absorbed, not counted twice.
- FSM, states IDLE, RING, SNOOZE:
  - IDLE: when (pending | match) is nonzero, grant the lowest index in that set. Go to RING at the same edge: active_idx=k, pending[k] cleared, led3=1, ring_cnt=RING_SECS-1, snooze_left=MAX_SNOOZE. Latency from the matching count sample to led3 high is one edge.
  - RING: each edge, if ring_cnt>0 then led3 toggles and ring_cnt decrements.
  - RING timeout: when ring_cnt==0, go to IDLE with led3=0. The event ends with no auto-snooze.
  - RING, dismiss=1: go to IDLE with led3=0.
  - RING, snooze=1 with snooze_left>0: go to SNOOZE, led3=0, snz_cnt=SNOOZE_SECS-1, snooze_left decrements.
  - RING, snooze=1 with snooze_left==0: ignored.
  - SNOOZE: snz_cnt decrements each edge. At 0, return to RING with led3=1 and ring_cnt=RING_SECS-1. snooze_left is not reset.
  - SNOOZE, dismiss=1: go to IDLE.
- Precedence and queueing:
  - dismiss and snooze in the same cycle: dismiss wins.
  - Matches during RING or SNOOZE are only queued in pending and are serviced in index order after return to IDLE, one per IDLE edge.
  - ringing = (state==RING).
- Widths: ring_cnt and snz_cnt are sized by clog2 of their parameter. count wrap-around (for example 86399→0) needs no special casing.

Optional Feature:
- Macro ALARM_MISSED_EN.
- With the macro defined:
  - Adds output missed (1 bit, sticky).
  - Sets when a slot matches while it is already pending, or while it is the active slot.
  - Clears on reset or on dismiss.
- Without the macro: no port; such matches are silently absorbed.

Decomposition:
- Shared package alarm_pkg holds:
  - state encoding (IDLE=2'd0, RING=2'd1, SNOOZE=2'd2);
  - default RING_SECS/SNOOZE_SECS/MAX_SNOOZE constants;
  - TIME_W.
- One sub-module, alarm_prio_enc: a combinational lowest-index-first priority encoder of N_SLOTS bits to IDX_W bits plus a valid bit.

Test Plan:
1. Single alarm:
   - Stimulus: write slot0 time=100, on; count steps 98→101.
   - Response: at the edge sampling count=100, ringing=1 and led3=1; led3 toggles for 60 edges, then 0 with state IDLE.
2. Held count:
   - Stimulus: slot1 time=200; count held at 200 for 5 edges.
   - Response: exactly one event; pending[1] never re-sets after grant.
3. Simultaneous match:
   - Stimulus: slots 0 and 2 both time=300.
   - Response: active_idx=0 first, pending=4'b0100; after dismiss, the next edge grants slot 2.
4. Snooze exhaustion:
   - Stimulus: snooze pressed in RING four times.
   - Response: after 3 snoozes (each 300-edge gap with led3=0), snooze_left=0; the 4th press is ignored and the ring times out to IDLE.
5. Precedence and reset:
   - Stimulus 1: snooze and dismiss both high in RING. Response: IDLE and led3=0.
   - Stimulus 2: rst_n pulsed low mid-SNOOZE. Response: all outputs at reset values immediately, and no alarm fires at the old times.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm scheduler: state encoding, default timing
// constants and the counter-width helper.
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } state_t;

    localparam int TIME_W      = 21;
    localparam int RING_SECS   = 60;
    localparam int SNOOZE_SECS = 300;
    localparam int MAX_SNOOZE  = 3;

    // A counter that must hold n-1 never needs fewer than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alarm_scheduler_if.sv
// Slot-programming, user-request and status bundle of the alarm scheduler.
// The missed flag exists only when ALARM_MISSED_EN is defined.
interface alarm_scheduler_if #(
    parameter int N_SLOTS = 4,
    parameter int TIME_W  = alarm_pkg::TIME_W,
    parameter int IDX_W   = 2
);
    logic [TIME_W-1:0]  count;
    logic               wr_en;
    logic [IDX_W-1:0]   wr_idx;
    logic [TIME_W-1:0]  wr_time;
    logic               wr_on;
    logic               snooze;
    logic               dismiss;
    logic               led3;
    logic               ringing;
    logic [IDX_W-1:0]   active_idx;
    logic [N_SLOTS-1:0] pending;
    logic [1:0]         snooze_left;
`ifdef ALARM_MISSED_EN
    logic               missed;

    modport master (
        output count, wr_en, wr_idx, wr_time, wr_on, snooze, dismiss,
        input  led3, ringing, active_idx, pending, snooze_left, missed
    );
    modport slave (
        input  count, wr_en, wr_idx, wr_time, wr_on, snooze, dismiss,
        output led3, ringing, active_idx, pending, snooze_left, missed
    );
`else
    modport master (
        output count, wr_en, wr_idx, wr_time, wr_on, snooze, dismiss,
        input  led3, ringing, active_idx, pending, snooze_left
    );
    modport slave (
        input  count, wr_en, wr_idx, wr_time, wr_on, snooze, dismiss,
        output led3, ringing, active_idx, pending, snooze_left
    );
`endif
endinterface

// File: rtl/alarm_prio_enc.sv
// Lowest-index-first priority encoder used to pick the next alarm slot to service.
module alarm_prio_enc #(
    parameter int N_SLOTS = 4,
    parameter int IDX_W   = 2
) (
    input  logic [N_SLOTS-1:0] req_i,
    output logic [IDX_W-1:0]   idx_o,
    output logic               valid_o
);

    // Scanning downward lets the lowest set bit overwrite any higher one.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o   = IDX_W'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alarm_scheduler.sv
// Multi-slot alarm controller: slot compare, pending queue and RING/SNOOZE sequencing.
// Define ALARM_MISSED_EN to add the sticky missed flag.
module alarm_scheduler #(
    parameter int N_SLOTS     = 4,
    parameter int TIME_W      = alarm_pkg::TIME_W,
    parameter int RING_SECS   = alarm_pkg::RING_SECS,
    parameter int SNOOZE_SECS = alarm_pkg::SNOOZE_SECS,
    parameter int MAX_SNOOZE  = alarm_pkg::MAX_SNOOZE,
    parameter int IDX_W       = 2
) (
    input  logic             clk_1hz,
    input  logic             rst_n,
    alarm_scheduler_if.slave bus
);
    import alarm_pkg::*;

    localparam int RING_W = cnt_width(RING_SECS);
    localparam int SNZ_W  = cnt_width(SNOOZE_SECS);

    state_t             state_q, state_d;
    logic               led_q, led_d;
    logic [RING_W-1:0]  ring_cnt_q, ring_cnt_d;
    logic [SNZ_W-1:0]   snz_cnt_q, snz_cnt_d;
    logic [IDX_W-1:0]   active_q, active_d;
    logic [1:0]         snz_left_q, snz_left_d;
    logic [N_SLOTS-1:0] pend_q, pend_d, en_q, en_d;
    logic [N_SLOTS-1:0] match, wr_hit, grant_clr, req;
    logic [TIME_W-1:0]  prev_q;
    logic [TIME_W-1:0]  slot_time_q [N_SLOTS];
    logic [TIME_W-1:0]  slot_time_d [N_SLOTS];
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_vld;
    logic               snz_ok;

    assign req    = pend_q | match;
    assign snz_ok = bus.snooze && (snz_left_q != 2'd0);

    alarm_prio_enc #(.N_SLOTS(N_SLOTS), .IDX_W(IDX_W)) u_prio_enc (
        .req_i   (req),
        .idx_o   (grant_idx),
        .valid_o (grant_vld)
    );

    // A match needs a fresh count value, so a held clock fires only once;
    // out-of-range write indices decode to no slot at all.
    always_comb begin
        en_d        = en_q;
        slot_time_d = slot_time_q;
        wr_hit      = '0;
        match       = '0;
        for (int k = 0; k < N_SLOTS; k++) begin
            wr_hit[k] = bus.wr_en && (bus.wr_idx == IDX_W'(k));
            if (wr_hit[k]) begin
                slot_time_d[k] = bus.wr_time;
                en_d[k]        = bus.wr_on;
            end
            match[k] = en_q[k] && (bus.count == slot_time_q[k]) && (bus.count != prev_q);
        end
        grant_clr = ((state_q == IDLE) && grant_vld) ? (N_SLOTS'(1) << grant_idx) : '0;
        pend_d    = (pend_q | match) & ~wr_hit & ~grant_clr;
    end

    always_ff @(posedge clk_1hz or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            led_q      <= 1'b0;
            ring_cnt_q <= '0;
            snz_cnt_q  <= '0;
            active_q   <= '0;
            snz_left_q <= 2'(MAX_SNOOZE);
            pend_q     <= '0;
            en_q       <= '0;
            prev_q     <= '0;
            for (int k = 0; k < N_SLOTS; k++) slot_time_q[k] <= '0;
        end else begin
            state_q     <= state_d;
            led_q       <= led_d;
            ring_cnt_q  <= ring_cnt_d;
            snz_cnt_q   <= snz_cnt_d;
            active_q    <= active_d;
            snz_left_q  <= snz_left_d;
            pend_q      <= pend_d;
            en_q        <= en_d;
            prev_q      <= bus.count;
            slot_time_q <= slot_time_d;
        end
    end

    // Dismiss beats snooze, and an allowed snooze beats the ring timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_vld) state_d = RING;
            RING: begin
                if (bus.dismiss)            state_d = IDLE;
                else if (snz_ok)            state_d = SNOOZE;
                else if (ring_cnt_q == '0)  state_d = IDLE;
            end
            SNOOZE: begin
                if (bus.dismiss)            state_d = IDLE;
                else if (snz_cnt_q == '0)   state_d = RING;
            end
            default:                        state_d = IDLE;
        endcase
    end

    always_comb begin
        led_d      = led_q;
        ring_cnt_d = ring_cnt_q;
        snz_cnt_d  = snz_cnt_q;
        active_d   = active_q;
        snz_left_d = snz_left_q;
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    active_d   = grant_idx;
                    led_d      = 1'b1;
                    ring_cnt_d = RING_W'(RING_SECS - 1);
                    snz_left_d = 2'(MAX_SNOOZE);
                end
            end
            RING: begin
                if (bus.dismiss) begin
                    led_d = 1'b0;
                end else if (snz_ok) begin
                    led_d      = 1'b0;
                    snz_cnt_d  = SNZ_W'(SNOOZE_SECS - 1);
                    snz_left_d = snz_left_q - 2'd1;
                end else if (ring_cnt_q == '0) begin
                    led_d = 1'b0;
                end else begin
                    led_d      = ~led_q;
                    ring_cnt_d = ring_cnt_q - RING_W'(1);
                end
            end
            SNOOZE: begin
                if (bus.dismiss) begin
                    led_d = 1'b0;
                end else if (snz_cnt_q == '0) begin
                    led_d      = 1'b1;
                    ring_cnt_d = RING_W'(RING_SECS - 1);
                end else begin
                    snz_cnt_d = snz_cnt_q - SNZ_W'(1);
                end
            end
            default: led_d = 1'b0;
        endcase
    end

    assign bus.led3        = led_q;
    assign bus.ringing     = (state_q == RING);
    assign bus.active_idx  = active_q;
    assign bus.pending     = pend_q;
    assign bus.snooze_left = snz_left_q;

`ifdef ALARM_MISSED_EN
    logic               missed_q, missed_d;
    logic [N_SLOTS-1:0] active_oh;

    // A repeat match on a queued or currently serviced slot is remembered until dismiss.
    always_comb begin
        active_oh = (state_q != IDLE) ? (N_SLOTS'(1) << active_q) : '0;
        missed_d  = (missed_q & ~bus.dismiss) | (|(match & (pend_q | active_oh)));
    end

    always_ff @(posedge clk_1hz or negedge rst_n) begin
        if (!rst_n) missed_q <= 1'b0;
        else        missed_q <= missed_d;
    end

    assign bus.missed = missed_q;
`endif

endmodule

// File: tb/tb_alarm_scheduler.sv
// Directed self-checking bench for alarm_scheduler with default parameters.
module tb_alarm_scheduler;

    logic clk_1hz = 1'b0;
    logic rst_n   = 1'b0;
    int   checks  = 0;
    int   errors  = 0;
    logic expLed;

    alarm_scheduler_if #(.N_SLOTS(4), .TIME_W(21), .IDX_W(2)) bus ();

    alarm_scheduler #(
        .N_SLOTS(4), .TIME_W(21), .RING_SECS(60), .SNOOZE_SECS(300),
        .MAX_SNOOZE(3), .IDX_W(2)
    ) dut (
        .clk_1hz (clk_1hz),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    always #5 clk_1hz = ~clk_1hz;

    // Drive one edge worth of inputs, then settle just past the rising edge.
    task automatic applyStimulus(input logic [20:0] cnt, input logic snz, input logic dis);
        bus.count   = cnt;
        bus.snooze  = snz;
        bus.dismiss = dis;
        @(posedge clk_1hz);
        #1;
    endtask

    task automatic writeSlot(input logic [1:0] idx, input logic [20:0] t, input logic on);
        bus.wr_en   = 1'b1;
        bus.wr_idx  = idx;
        bus.wr_time = t;
        bus.wr_on   = on;
        @(posedge clk_1hz);
        #1;
        bus.wr_en   = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkIdleReset(input string tag);
        checkOutput({tag, "_led3"},    32'(bus.led3),        32'd0);
        checkOutput({tag, "_ringing"}, 32'(bus.ringing),     32'd0);
        checkOutput({tag, "_active"},  32'(bus.active_idx),  32'd0);
        checkOutput({tag, "_pending"}, 32'(bus.pending),     32'd0);
        checkOutput({tag, "_snzleft"}, 32'(bus.snooze_left), 32'd3);
    endtask

    initial begin
        bus.count   = '0;
        bus.wr_en   = 1'b0;
        bus.wr_idx  = '0;
        bus.wr_time = '0;
        bus.wr_on   = 1'b0;
        bus.snooze  = 1'b0;
        bus.dismiss = 1'b0;

        // Reset values
        repeat (2) @(posedge clk_1hz);
        #3;
        checkIdleReset("reset");
        rst_n = 1'b1;
        @(posedge clk_1hz);
        #1;

        // Single alarm on slot0 at 100
        writeSlot(2'd0, 21'd100, 1'b1);
        applyStimulus(21'd98, 1'b0, 1'b0);
        applyStimulus(21'd99, 1'b0, 1'b0);
        checkOutput("t1_pre_ringing", 32'(bus.ringing), 32'd0);
        applyStimulus(21'd100, 1'b0, 1'b0);
        checkOutput("t1_ringing", 32'(bus.ringing), 32'd1);
        checkOutput("t1_led3", 32'(bus.led3), 32'd1);
        checkOutput("t1_active", 32'(bus.active_idx), 32'd0);
        checkOutput("t1_pending", 32'(bus.pending), 32'd0);
        expLed = 1'b1;
        for (int k = 1; k <= 59; k++) begin
            applyStimulus(21'd101, 1'b0, 1'b0);
            expLed = ~expLed;
            checkOutput("t1_toggle", 32'(bus.led3), 32'(expLed));
        end
        checkOutput("t1_last_ringing", 32'(bus.ringing), 32'd1);
        applyStimulus(21'd101, 1'b0, 1'b0);
        checkOutput("t1_timeout_ringing", 32'(bus.ringing), 32'd0);
        checkOutput("t1_timeout_led3", 32'(bus.led3), 32'd0);

        // Held count fires once
        writeSlot(2'd1, 21'd200, 1'b1);
        applyStimulus(21'd199, 1'b0, 1'b0);
        applyStimulus(21'd200, 1'b0, 1'b0);
        checkOutput("t2_ringing", 32'(bus.ringing), 32'd1);
        checkOutput("t2_active", 32'(bus.active_idx), 32'd1);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(21'd200, 1'b0, 1'b0);
            checkOutput("t2_held_pending", 32'(bus.pending), 32'd0);
        end
        applyStimulus(21'd200, 1'b0, 1'b1);
        checkOutput("t2_dismiss_ringing", 32'(bus.ringing), 32'd0);
        applyStimulus(21'd200, 1'b0, 1'b0);
        applyStimulus(21'd200, 1'b0, 1'b0);
        checkOutput("t2_no_refire", 32'(bus.ringing), 32'd0);
        checkOutput("t2_no_pending", 32'(bus.pending), 32'd0);

        // Simultaneous match on slots 0 and 2
        writeSlot(2'd0, 21'd300, 1'b1);
        writeSlot(2'd2, 21'd300, 1'b1);
        applyStimulus(21'd299, 1'b0, 1'b0);
        applyStimulus(21'd300, 1'b0, 1'b0);
        checkOutput("t3_active_first", 32'(bus.active_idx), 32'd0);
        checkOutput("t3_pending_q", 32'(bus.pending), 32'b0100);
        applyStimulus(21'd300, 1'b0, 1'b1);
        checkOutput("t3_dismiss_ringing", 32'(bus.ringing), 32'd0);
        checkOutput("t3_still_pending", 32'(bus.pending), 32'b0100);
        applyStimulus(21'd300, 1'b0, 1'b0);
        checkOutput("t3_second_ringing", 32'(bus.ringing), 32'd1);
        checkOutput("t3_active_second", 32'(bus.active_idx), 32'd2);
        checkOutput("t3_pending_empty", 32'(bus.pending), 32'd0);
        applyStimulus(21'd300, 1'b0, 1'b1);

        // Snooze exhaustion on slot3
        writeSlot(2'd3, 21'd400, 1'b1);
        applyStimulus(21'd399, 1'b0, 1'b0);
        applyStimulus(21'd400, 1'b0, 1'b0);
        checkOutput("t4_ringing", 32'(bus.ringing), 32'd1);
        checkOutput("t4_active", 32'(bus.active_idx), 32'd3);
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(21'd400, 1'b1, 1'b0);
            checkOutput("t4_snz_ringing", 32'(bus.ringing), 32'd0);
            checkOutput("t4_snz_led3", 32'(bus.led3), 32'd0);
            checkOutput("t4_snz_left", 32'(bus.snooze_left), 32'(3 - i));
            for (int k = 0; k < 299; k++) applyStimulus(21'd400, 1'b0, 1'b0);
            checkOutput("t4_gap_ringing", 32'(bus.ringing), 32'd0);
            checkOutput("t4_gap_led3", 32'(bus.led3), 32'd0);
            applyStimulus(21'd400, 1'b0, 1'b0);
            checkOutput("t4_rering", 32'(bus.ringing), 32'd1);
            checkOutput("t4_rering_led3", 32'(bus.led3), 32'd1);
        end
        applyStimulus(21'd400, 1'b1, 1'b0);
        checkOutput("t4_ignored_ringing", 32'(bus.ringing), 32'd1);
        checkOutput("t4_ignored_left", 32'(bus.snooze_left), 32'd0);
        checkOutput("t4_ignored_led3", 32'(bus.led3), 32'd0);
        for (int k = 0; k < 58; k++) applyStimulus(21'd400, 1'b0, 1'b0);
        checkOutput("t4_final_ringing", 32'(bus.ringing), 32'd1);
        applyStimulus(21'd400, 1'b0, 1'b0);
        checkOutput("t4_timeout_ringing", 32'(bus.ringing), 32'd0);
        checkOutput("t4_timeout_led3", 32'(bus.led3), 32'd0);

        // Dismiss beats snooze
        writeSlot(2'd0, 21'd500, 1'b1);
        applyStimulus(21'd499, 1'b0, 1'b0);
        applyStimulus(21'd500, 1'b0, 1'b0);
        checkOutput("t5_ringing", 32'(bus.ringing), 32'd1);
        applyStimulus(21'd500, 1'b1, 1'b1);
        checkOutput("t5_both_ringing", 32'(bus.ringing), 32'd0);
        checkOutput("t5_both_led3", 32'(bus.led3), 32'd0);
        checkOutput("t5_both_left", 32'(bus.snooze_left), 32'd3);

        // Reset mid-snooze with a queued match
        writeSlot(2'd2, 21'd600, 1'b1);
        applyStimulus(21'd599, 1'b0, 1'b0);
        applyStimulus(21'd600, 1'b0, 1'b0);
        checkOutput("t5r_active", 32'(bus.active_idx), 32'd2);
        applyStimulus(21'd600, 1'b1, 1'b0);
        checkOutput("t5r_snz_left", 32'(bus.snooze_left), 32'd2);
        writeSlot(2'd1, 21'd602, 1'b1);
        applyStimulus(21'd601, 1'b0, 1'b0);
        applyStimulus(21'd602, 1'b0, 1'b0);
        checkOutput("t5r_queued", 32'(bus.pending), 32'b0010);
        #2;
        rst_n = 1'b0;
        #1;
        checkIdleReset("t5r_async");
        #3;
        rst_n = 1'b1;
        applyStimulus(21'd599, 1'b0, 1'b0);
        applyStimulus(21'd600, 1'b0, 1'b0);
        applyStimulus(21'd601, 1'b0, 1'b0);
        applyStimulus(21'd602, 1'b0, 1'b0);
        checkOutput("t5r_no_fire_ringing", 32'(bus.ringing), 32'd0);
        checkOutput("t5r_no_fire_pending", 32'(bus.pending), 32'd0);
        checkOutput("t5r_no_fire_led3", 32'(bus.led3), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
